csr_initiator: RTL and testbench

CSR_INITIATOR -- requirements
Module: csr_initiator

---
 rtl/config_pkg.sv | 13 +
 rtl/decoder_pkg.sv | 22 ++
 rtl/csr_req_fifo.sv | 50 +++++
 rtl/csr_initiator.sv | 117 +++++++++++
 tb/tb_csr_initiator.sv | 264 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/config_pkg.sv
// Architectural widths shared across the core: data word, CSR address
// and register index.
package config_pkg;

    localparam int XLEN       = 32;
    localparam int CsrAddrW   = 12;
    localparam int RegIdxW    = 5;

    typedef logic [XLEN-1:0]     word;
    typedef logic [CsrAddrW-1:0] CsrAddrT;
    typedef logic [RegIdxW-1:0]  r;

endpackage

// File: rtl/decoder_pkg.sv
// Decoder-level types: CSR operation encoding (funct3) and the buffered
// CSR request record used by the CSR initiator.
package decoder_pkg;

    typedef enum logic [2:0] {
        CSR_NONE = 3'b000,
        CSRRW    = 3'b001,
        CSRRS    = 3'b010,
        CSRRC    = 3'b011,
        CSRRWI   = 3'b101,
        CSRRSI   = 3'b110,
        CSRRCI   = 3'b111
    } csr_op_t;

    typedef struct packed {
        config_pkg::CsrAddrT addr;
        csr_op_t             op;
        config_pkg::r        zimm;
        config_pkg::word     data;
    } csr_req_t;

endpackage

// File: rtl/csr_req_fifo.sv
// Request buffer for the CSR initiator: a power-of-two FIFO whose pointers
// carry one extra wrap bit so full and empty can be told apart.
module csr_req_fifo
    import decoder_pkg::*;
#(
    parameter int FifoDepth = 2
) (
    input  logic     clk,
    input  logic     reset,
    input  logic     push,
    input  csr_req_t push_data,
    input  logic     pop,
    output csr_req_t head,
    output logic     full,
    output logic     empty
);

    localparam int AddrW = $clog2(FifoDepth);

    logic [AddrW:0] wr_ptr;
    logic [AddrW:0] rd_ptr;
    csr_req_t       mem [FifoDepth];

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push && !full) begin
                wr_ptr <= wr_ptr + (AddrW + 1)'(1);
            end
            if (pop && !empty) begin
                rd_ptr <= rd_ptr + (AddrW + 1)'(1);
            end
        end
    end

    // Storage needs no reset; only the pointers decide what is valid.
    always_ff @(posedge clk) begin
        if (push && !full) begin
            mem[wr_ptr[AddrW-1:0]] <= push_data;
        end
    end

    assign head  = mem[rd_ptr[AddrW-1:0]];
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AddrW] != rd_ptr[AddrW]) &&
                   (wr_ptr[AddrW-1:0] == rd_ptr[AddrW-1:0]);

endmodule

// File: rtl/csr_initiator.sv
// Buffers external CSR requests and issues them one at a time onto the
// shared CSR bus whenever the core pipeline is not using it.
module csr_initiator
    import config_pkg::*;
    import decoder_pkg::*;
#(
    parameter int FifoDepth = 2
) (
    input  logic    clk,
    input  logic    reset,
    input  logic    req_valid,
    output logic    req_ready,
    input  CsrAddrT req_addr,
    input  csr_op_t req_op,
    input  r        req_zimm,
    input  word     req_data,
    input  logic    core_csr_busy,
    output logic    csr_enable,
    output CsrAddrT csr_addr,
    output csr_op_t csr_op,
    output r        rs1_zimm,
    output word     rs1_data,
    input  word     csr_rdata,
    output logic    rsp_valid,
    input  logic    rsp_ready,
    output word     rsp_data
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        RESP
    } state_t;

    state_t   state;
    state_t   state_next;
    logic     issue;
    logic     fifo_full;
    logic     fifo_empty;
    csr_req_t fifo_head;
    csr_req_t push_req;

    assign req_ready = !fifo_full;
    assign push_req  = '{addr: req_addr, op: req_op, zimm: req_zimm, data: req_data};

    csr_req_fifo #(
        .FifoDepth (FifoDepth)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (req_valid),
        .push_data (push_req),
        .pop       (issue),
        .head      (fifo_head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // The core owns the bus whenever it asks; we only issue on a free cycle.
    always_comb begin
        state_next = state;
        issue      = 1'b0;
        case (state)
            IDLE: begin
                if (!fifo_empty) begin
                    state_next = ISSUE;
                end
            end
            ISSUE: begin
                if (!core_csr_busy) begin
                    issue      = 1'b1;
                    state_next = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign csr_enable = issue && !reset;
    assign rsp_valid  = (state == RESP) && !reset;

    // Bus fields are zero whenever we are not strobing, so they can be OR-muxed upstream.
    always_comb begin
        csr_addr = '0;
        csr_op   = CSR_NONE;
        rs1_zimm = '0;
        rs1_data = '0;
        if (csr_enable) begin
            csr_addr = fifo_head.addr;
            csr_op   = fifo_head.op;
            rs1_zimm = fifo_head.zimm;
            rs1_data = fifo_head.data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            rsp_data <= '0;
        end else if (issue) begin
            rsp_data <= csr_rdata;
        end
    end

endmodule

// File: tb/tb_csr_initiator.sv
// Directed self-checking bench for csr_initiator: a vector table of single
// transactions plus hand-written backpressure and mid-operation reset sequences.
module tb_csr_initiator;
    import config_pkg::*;
    import decoder_pkg::*;

    logic    clk = 1'b0;
    logic    reset;
    logic    req_valid;
    logic    req_ready;
    CsrAddrT req_addr;
    csr_op_t req_op;
    r        req_zimm;
    word     req_data;
    logic    core_csr_busy;
    logic    csr_enable;
    CsrAddrT csr_addr;
    csr_op_t csr_op;
    r        rs1_zimm;
    word     rs1_data;
    word     csr_rdata;
    logic    rsp_valid;
    logic    rsp_ready;
    word     rsp_data;

    int num_vectors     = 0;
    int num_miscompares = 0;

    logic [11:0] issued_addr [0:63];
    int          issued_count = 0;

    typedef struct {
        logic [11:0] addr;
        logic [2:0]  op;
        logic [4:0]  zimm;
        logic [31:0] data;
        logic [31:0] rdata;
        int          busy_cycles;
        int          hold_cycles;
        int          exp_latency;
        logic [31:0] exp_rsp;
    } vec_t;

    vec_t vectors [6];

    csr_initiator #(
        .FifoDepth (2)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_op        (req_op),
        .req_zimm      (req_zimm),
        .req_data      (req_data),
        .core_csr_busy (core_csr_busy),
        .csr_enable    (csr_enable),
        .csr_addr      (csr_addr),
        .csr_op        (csr_op),
        .rs1_zimm      (rs1_zimm),
        .rs1_data      (rs1_data),
        .csr_rdata     (csr_rdata),
        .rsp_valid     (rsp_valid),
        .rsp_ready     (rsp_ready),
        .rsp_data      (rsp_data)
    );

    always #5 clk = ~clk;

    // Log every bus strobe so issue order and issue count can be checked.
    always @(negedge clk) begin
        #2;
        if (csr_enable === 1'b1) begin
            if (issued_count < 64) begin
                issued_addr[issued_count] = csr_addr;
            end
            issued_count = issued_count + 1;
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        num_vectors = num_vectors + 1;
        if (act !== exp) begin
            num_miscompares = num_miscompares + 1;
            $display("[TB] FAIL %s: got 0x%08h, required 0x%08h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int idx);
        int    base;
        string tag;
        base = issued_count;
        tag  = $sformatf("vec%0d", idx);
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = v.addr;
        req_op    = csr_op_t'(v.op);
        req_zimm  = v.zimm;
        req_data  = v.data;
        csr_rdata = v.rdata;
        #1 checkOutput({tag, "_req_ready"}, 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_valid     = 1'b0;
        core_csr_busy = (v.busy_cycles > 0);
        #1;
        checkOutput({tag, "_enable_n1"}, 32'(csr_enable), 32'd0);
        checkOutput({tag, "_idle_addr_zero"}, 32'(csr_addr), 32'd0);
        for (int t = 2; t <= v.exp_latency; t++) begin
            @(negedge clk);
            if (t == 2 + v.busy_cycles) begin
                core_csr_busy = 1'b0;
            end
            #1 checkOutput($sformatf("%s_enable_n%0d", tag, t), 32'(csr_enable),
                           32'(t == v.exp_latency));
        end
        checkOutput({tag, "_csr_addr"}, 32'(csr_addr), 32'(v.addr));
        checkOutput({tag, "_csr_op"}, 32'(csr_op), 32'(v.op));
        checkOutput({tag, "_rs1_zimm"}, 32'(rs1_zimm), 32'(v.zimm));
        checkOutput({tag, "_rs1_data"}, rs1_data, v.data);
        @(negedge clk);
        #1;
        checkOutput({tag, "_rsp_valid"}, 32'(rsp_valid), 32'd1);
        checkOutput({tag, "_rsp_data"}, rsp_data, v.exp_rsp);
        checkOutput({tag, "_enable_in_resp"}, 32'(csr_enable), 32'd0);
        for (int h = 0; h < v.hold_cycles; h++) begin
            @(negedge clk);
            #1;
            checkOutput($sformatf("%s_hold%0d_valid", tag, h), 32'(rsp_valid), 32'd1);
            checkOutput($sformatf("%s_hold%0d_data", tag, h), rsp_data, v.exp_rsp);
            checkOutput($sformatf("%s_hold%0d_enable", tag, h), 32'(csr_enable), 32'd0);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
        #1;
        checkOutput({tag, "_rsp_done"}, 32'(rsp_valid), 32'd0);
        checkOutput({tag, "_issue_once"}, 32'(issued_count - base), 32'd1);
    endtask

    initial begin
        int base;
        int snap;
        bit accepted;

        reset         = 1'b1;
        req_valid     = 1'b0;
        req_addr      = '0;
        req_op        = CSR_NONE;
        req_zimm      = '0;
        req_data      = '0;
        core_csr_busy = 1'b0;
        csr_rdata     = '0;
        rsp_ready     = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        checkOutput("reset_enable", 32'(csr_enable), 32'd0);
        checkOutput("reset_rsp_valid", 32'(rsp_valid), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        #1;
        checkOutput("post_reset_req_ready", 32'(req_ready), 32'd1);
        checkOutput("post_reset_rsp_data", rsp_data, 32'd0);
        checkOutput("post_reset_csr_addr", 32'(csr_addr), 32'd0);
        checkOutput("post_reset_rs1_data", rs1_data, 32'd0);
        checkOutput("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);

        // addr, op, zimm, data, rdata, busy, hold, expected latency, expected response
        vectors[0] = '{12'h305, 3'b001, 5'd5,  32'hDEADBEEF, 32'h00000100, 0, 0, 2, 32'h00000100};
        vectors[1] = '{12'h300, 3'b010, 5'd0,  32'h00000000, 32'h00001888, 0, 0, 2, 32'h00001888};
        vectors[2] = '{12'h341, 3'b011, 5'd3,  32'h12345678, 32'h80000004, 3, 0, 5, 32'h80000004};
        vectors[3] = '{12'h340, 3'b101, 5'd31, 32'hFFFFFFFF, 32'hCAFEF00D, 0, 5, 2, 32'hCAFEF00D};
        vectors[4] = '{12'hFFF, 3'b100, 5'd17, 32'hA5A5A5A5, 32'h5A5A5A5A, 1, 2, 3, 32'h5A5A5A5A};
        vectors[5] = '{12'h001, 3'b111, 5'd0,  32'h0000FFFF, 32'h00000000, 0, 0, 2, 32'h00000000};

        for (int i = 0; i < 6; i++) begin
            applyStimulus(vectors[i], i);
        end

        $display("[TB] backpressure sequence");
        base      = issued_count;
        csr_rdata = 32'h0000_0042;
        @(negedge clk);
        req_valid = 1'b1;
        req_op    = CSRRW;
        req_zimm  = 5'd1;
        req_data  = 32'h1111_0000;
        req_addr  = 12'h100;
        #1 checkOutput("bp_ready_first", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_addr = 12'h200;
        #1 checkOutput("bp_ready_second", 32'(req_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        req_addr = 12'h300;
        #1 checkOutput("bp_ready_full", 32'(req_ready), 32'd0);
        accepted = 1'b0;
        for (int i = 0; i < 10 && !accepted; i++) begin
            @(posedge clk);
            @(negedge clk);
            if (req_ready) begin
                @(posedge clk);
                accepted = 1'b1;
            end
        end
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("bp_third_accepted", 32'(accepted), 32'd1);
        rsp_ready = 1'b1;
        for (int i = 0; i < 40 && issued_count < base + 3; i++) begin
            @(negedge clk);
        end
        repeat (4) @(negedge clk);
        rsp_ready = 1'b0;
        #3;
        checkOutput("bp_issue_count", 32'(issued_count - base), 32'd3);
        checkOutput("bp_order_0", 32'(issued_addr[base]), 32'h100);
        checkOutput("bp_order_1", 32'(issued_addr[base + 1]), 32'h200);
        checkOutput("bp_order_2", 32'(issued_addr[base + 2]), 32'h300);
        checkOutput("bp_idle_rsp_valid", 32'(rsp_valid), 32'd0);

        $display("[TB] mid-operation reset sequence");
        csr_rdata = 32'h0BAD_F00D;
        @(negedge clk);
        req_valid = 1'b1;
        req_addr  = 12'h7C0;
        @(posedge clk);
        @(negedge clk);
        req_addr = 12'h7C1;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        @(negedge clk);
        #1 checkOutput("rst_in_resp", 32'(rsp_valid), 32'd1);
        reset = 1'b1;
        #1 checkOutput("rst_rsp_valid_during", 32'(rsp_valid), 32'd0);
        snap = issued_count;
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        checkOutput("rst_rsp_valid_after", 32'(rsp_valid), 32'd0);
        checkOutput("rst_req_ready_after", 32'(req_ready), 32'd1);
        checkOutput("rst_rsp_data_after", rsp_data, 32'd0);
        repeat (8) @(negedge clk);
        #3;
        checkOutput("rst_no_flushed_issue", 32'(issued_count - snap), 32'd0);
        checkOutput("rst_rsp_valid_late", 32'(rsp_valid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", num_vectors, num_miscompares);
        $finish;
    end

endmodule
